// File: rtl/cpu_pkg.sv
// cpu_pkg: definitions shared by the fetch stage and the main decoder.
//   OP_BEQ / OP_B : branch opcodes (instr[15:12])
//   fetch_state_t : fetch_unit state encoding. HALT is present only when
//                   FETCH_HALT_EN is defined.
package cpu_pkg;

  localparam logic [3:0] OP_BEQ = 4'd14;
  localparam logic [3:0] OP_B   = 4'd15;

`ifdef FETCH_HALT_EN
  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    HALT  = 2'd2
  } fetch_state_t;
`else
  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1
  } fetch_state_t;
`endif

endpackage

// File: rtl/fetch_next_pc.sv
// fetch_next_pc: combinational next-PC selection for the fetch stage.
//   instr    in  : instruction currently held by fetch
//   pc_out   in  : address instr was fetched from
//   br_taken in  : BEQ condition from execute
//   next_pc  out : B target, taken-BEQ target, or pc_out + 1 (all mod 2^PC_W)
module fetch_next_pc
  import cpu_pkg::*;
#(
  parameter int PC_W    = 8,
  parameter int INSTR_W = 16
) (
  input  logic [INSTR_W-1:0] instr,
  input  logic [PC_W-1:0]    pc_out,
  input  logic               br_taken,
  output logic [PC_W-1:0]    next_pc
);

  logic [3:0]      op;
  logic [11:0]     b_field;
  logic [PC_W-1:0] seq_pc;
  logic [PC_W-1:0] br_off;
  logic [PC_W-1:0] b_target;

  assign op       = instr[INSTR_W-1 -: 4];
  assign b_field  = instr[11:0];
  assign seq_pc   = pc_out + PC_W'(1);
  // 4-bit signed BEQ offset, relative to the sequential PC
  assign br_off   = {{(PC_W-4){instr[3]}}, instr[3:0]};
  // B target is the 12-bit field truncated or zero-extended to PC_W
  assign b_target = PC_W'(b_field);

  always_comb begin
    next_pc = seq_pc;
    if (op == OP_B) begin
      next_pc = b_target;
    end else if (op == OP_BEQ && br_taken) begin
      next_pc = seq_pc + br_off;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage. Holds the PC, requests words from
// instruction memory (valid/ack) and hands them to the decoder (valid/ready).
// Optional feature macro: FETCH_HALT_EN (accepting a self-branch B halts fetch).
//   clk, reset (async, active-high)
//   imem_req/imem_addr/imem_rdata/imem_ack : instruction memory port
//   instr/op/pc_out/instr_valid/instr_ready : decoder port
//   br_taken : BEQ condition, used only when a BEQ is accepted
//   halted   : fetch stopped on a self-branch (0 when FETCH_HALT_EN undefined)
//
// state | meaning
// FETCH | request outstanding at pc_q, waiting for imem_ack
// HOLD  | instruction presented to decoder, waiting for accept
// HALT  | self-branch accepted, fetch stopped until reset
module fetch_unit
  import cpu_pkg::*;
#(
  parameter int              PC_W     = 8,
  parameter int              INSTR_W  = 16,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               reset,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               imem_ack,
  output logic [INSTR_W-1:0] instr,
  output logic [3:0]         op,
  output logic [PC_W-1:0]    pc_out,
  output logic               instr_valid,
  input  logic               instr_ready,
  input  logic               br_taken,
  output logic               halted
);

  fetch_state_t        state_q, state_d;
  logic [PC_W-1:0]     pc_q, pc_d;
  logic [INSTR_W-1:0]  instr_q, instr_d;
  logic [PC_W-1:0]     pc_out_q, pc_out_d;
  // Keeps imem_req low while reset is held and until the first edge after it.
  logic                run_q, run_d;
  logic [PC_W-1:0]     next_pc;

  fetch_next_pc #(
    .PC_W    (PC_W),
    .INSTR_W (INSTR_W)
  ) u_next_pc (
    .instr    (instr_q),
    .pc_out   (pc_out_q),
    .br_taken (br_taken),
    .next_pc  (next_pc)
  );

  assign imem_addr = pc_q;
  assign instr     = instr_q;
  assign op        = instr_q[INSTR_W-1 -: 4];
  assign pc_out    = pc_out_q;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    instr_d     = instr_q;
    pc_out_d    = pc_out_q;
    run_d       = 1'b1;
    imem_req    = 1'b0;
    instr_valid = 1'b0;
    halted      = 1'b0;
    case (state_q)
      FETCH: begin
        imem_req = run_q;
        if (run_q && imem_ack) begin
          instr_d  = imem_rdata;
          pc_out_d = pc_q;
          state_d  = HOLD;
        end
      end
      HOLD: begin
        instr_valid = 1'b1;
        if (instr_ready) begin
          pc_d    = next_pc;
          state_d = FETCH;
`ifdef FETCH_HALT_EN
          if (op == OP_B && next_pc == pc_out_q) begin
            state_d = HALT;
          end
`endif
        end
      end
`ifdef FETCH_HALT_EN
      HALT: begin
        halted = 1'b1;
      end
`endif
      default: begin
        state_d = FETCH;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= FETCH;
      pc_q     <= RESET_PC;
      instr_q  <= '0;
      pc_out_q <= RESET_PC;
      run_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      instr_q  <= instr_d;
      pc_out_q <= pc_out_d;
      run_q    <= run_d;
    end
  end

endmodule
